// File: rtl/rr_wb_stream2axi_if.sv
// rtl/rr_wb_stream2axi_if.sv - writeback stream input and AXI4 write channels for rr_wb_stream2axi
interface rr_wb_stream2axi_if #(
  parameter int DATA_W = 512
) ();
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [63:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [15:0]         awid;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output awaddr, awlen, awsize, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  awaddr, awlen, awsize, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/rr_wb_stream2axi.sv
// rtl/rr_wb_stream2axi.sv - buffers a writeback stream and writes it as AXI4 INCR bursts into a ring buffer
module rr_wb_stream2axi #(
  parameter int          DATA_W     = 512,
  parameter int          BURST_LEN  = 64,
  parameter int          FIFO_DEPTH = 128,
  parameter int          MAX_OUTST  = 8,
  parameter logic [15:0] AXI_ID     = 16'h0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_en,
  input  logic [63:0]        cfg_base,
  input  logic [63:0]        cfg_size,
  input  logic               flush,
  rr_wb_stream2axi_if.master bus,
  output logic [63:0]        wr_ptr,
  output logic [63:0]        bytes_done,
  output logic               err,
  output logic               idle
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int LW  = $clog2(BURST_LEN) + 1;
  localparam int OW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OCW = $clog2(MAX_OUTST + 1);
  localparam int BPB = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [CW-1:0]     r_cnt;
  logic              r_rdy_en;
  logic [LW-1:0]     r_len;
  logic [LW-1:0]     r_beat;
  logic [63:0]       r_ptr;
  logic [OCW-1:0]    r_outst;
  logic [63:0]       r_bq [MAX_OUTST];
  logic [OW-1:0]     r_bq_wp;
  logic [OW-1:0]     r_bq_rp;
  logic [63:0]       r_done;
  logic              r_err;
  logic              r_flush;

  logic              w_push;
  logic              w_pop;
  logic              w_aw_hs;
  logic              w_b;
  logic              w_start;
  logic [LW-1:0]     w_n;
  logic [63:0]       w_bytes;
  logic [63:0]       w_ptr_rnd;
  logic [63:0]       w_ptr_nxt;

  assign w_push  = bus.in_valid && bus.in_ready;
  assign w_pop   = bus.wvalid && bus.wready;
  assign w_aw_hs = bus.awvalid && bus.awready;
  // B beats with nothing outstanding are ignored so the counters stay consistent
  assign w_b     = bus.bvalid && (r_outst != '0);
  assign w_start = cfg_en && (r_outst < OCW'(MAX_OUTST)) &&
                   ((r_cnt >= CW'(BURST_LEN)) || (r_flush && (r_cnt != '0)));
  assign w_n     = (r_cnt >= CW'(BURST_LEN)) ? LW'(BURST_LEN) : LW'(r_cnt);
  assign w_bytes = 64'(r_len) * 64'(BPB);
  // Round up to the next 4 KiB page so a short burst never leaves the pointer mid-page
  assign w_ptr_rnd = (r_ptr + w_bytes + 64'hFFF) & ~64'hFFF;
  assign w_ptr_nxt = (w_ptr_rnd >= cfg_size) ? 64'd0 : w_ptr_rnd;

  assign bus.in_ready = r_rdy_en && (r_cnt != CW'(FIFO_DEPTH));
  assign bus.awaddr   = cfg_base + r_ptr;
  assign bus.awlen    = 8'(r_len) - 8'd1;
  assign bus.awsize   = 3'($clog2(BPB));
  assign bus.awid     = {1'b0, AXI_ID[14:0]};
  assign bus.wdata    = r_mem[r_rp];
  assign bus.wstrb    = '1;
  assign bus.bready   = 1'b1;

  assign wr_ptr     = r_ptr;
  assign bytes_done = r_done;
  assign err        = r_err;
  assign idle       = (r_cnt == '0) && (r_state == S_IDLE) && (r_outst == '0);

  // Hold in_ready low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rdy_en <= 1'b0;
    else       r_rdy_en <= 1'b1;
  end

  // Input FIFO storage; validity is tracked by the pointers, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= bus.in_data;
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // FSM state register plus latched burst length and beat counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && w_start) r_len <= w_n;
      if (r_state == S_ADDR)              r_beat <= '0;
      else if (w_pop)                     r_beat <= r_beat + LW'(1);
    end
  end

  // FSM next state and AW/W channel valids
  always_comb begin
    w_state_nxt = r_state;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.wlast   = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_ADDR;
      S_ADDR: begin
        bus.awvalid = 1'b1;
        if (bus.awready) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        bus.wvalid = 1'b1;
        bus.wlast  = (r_beat == (r_len - LW'(1)));
        if (bus.wready && bus.wlast) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-burst byte counts, in issue order, waiting for their B response
  always_ff @(posedge clk) begin
    if (w_aw_hs) r_bq[r_bq_wp] <= w_bytes;
  end

  // Ring pointer, outstanding bursts, completion accounting, error and flush flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr   <= '0;
      r_outst <= '0;
      r_bq_wp <= '0;
      r_bq_rp <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_ptr   <= w_ptr_nxt;
        r_bq_wp <= (r_bq_wp == OW'(MAX_OUTST - 1)) ? '0 : r_bq_wp + OW'(1);
      end
      case ({w_aw_hs, w_b})
        2'b10:   if (r_outst != OCW'(MAX_OUTST)) r_outst <= r_outst + OCW'(1);
        2'b01:   r_outst <= r_outst - OCW'(1);
        default: ;
      endcase
      if (w_b) begin
        r_bq_rp <= (r_bq_rp == OW'(MAX_OUTST - 1)) ? '0 : r_bq_rp + OW'(1);
        r_done  <= r_done + r_bq[r_bq_rp];
      end
      if (bus.bvalid && (bus.bresp != 2'b00)) r_err <= 1'b1;
      if (flush)                                   r_flush <= 1'b1;
      else if ((r_state == S_IDLE) && (r_cnt == '0)) r_flush <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_wb_stream2axi.sv
// tb/tb_rr_wb_stream2axi.sv - self-checking bench for rr_wb_stream2axi
module tb_rr_wb_stream2axi;
  localparam int          DW   = 512;
  localparam logic [63:0] BASE = 64'h1000_0000;

  logic        clk      = 1'b0;
  logic        rstn     = 1'b0;
  logic        cfg_en   = 1'b0;
  logic [63:0] cfg_base = BASE;
  logic [63:0] cfg_size = 64'h4000;
  logic        flush    = 1'b0;
  logic [63:0] wr_ptr;
  logic [63:0] bytes_done;
  logic        err;
  logic        idle;

  rr_wb_stream2axi_if #(.DATA_W(DW)) bus ();

  rr_wb_stream2axi dut (
    .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .cfg_base(cfg_base), .cfg_size(cfg_size),
    .flush(flush), .bus(bus), .wr_ptr(wr_ptr), .bytes_done(bytes_done), .err(err), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int            to_send;
  logic [DW-1:0] next_data;
  logic [DW-1:0] sb[$];
  int            m_cnt;
  bit            rnd;
  bit            flush_req;
  int            b_budget;
  int            err_idx;
  int            naws, nw, nb, cur_beat, last_len;
  int            aw_len_q[$];
  int            aw_bcnt[$];
  logic [63:0]   pend_b[$];
  logic [63:0]   m_ptr;
  logic [63:0]   m_done;

  typedef struct {
    int          beats;
    bit          fl;
    logic [63:0] size;
    int          exp_aws;
    int          exp_last;
    logic [63:0] exp_ptr;
    logic [63:0] exp_done;
  } row_t;
  row_t rows[7];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.in_valid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00; flush = 1'b0;
    to_send = 0; sb.delete(); m_cnt = 0; rnd = 0; flush_req = 0;
    b_budget = 1 << 30; err_idx = -1;
    naws = 0; nw = 0; nb = 0; cur_beat = 0; last_len = -1;
    aw_len_q.delete(); aw_bcnt.delete(); pend_b.delete();
    m_ptr = 64'd0; m_done = 64'd0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // One clock: drive inputs at negedge, then score what the next posedge will commit
  task automatic step();
    logic [63:0] nxt;
    int          len;
    @(negedge clk);
    flush        = flush_req;
    bus.in_valid = (to_send > 0) && (!rnd || ($urandom_range(1) == 1));
    bus.in_data  = next_data;
    bus.awready  = !rnd || ($urandom_range(1) == 1);
    bus.wready   = !rnd || ($urandom_range(3) != 0);
    if (pend_b.size() > 0 && b_budget > 0 && (!rnd || ($urandom_range(1) == 1))) begin
      bus.bvalid = 1'b1;
      bus.bresp  = (nb == err_idx) ? 2'b10 : 2'b00;
    end else begin
      bus.bvalid = 1'b0;
      bus.bresp  = 2'b00;
    end
    #1;
    chk("in_ready_vs_count", bus.in_ready, (m_cnt < 128) ? 1 : 0);
    if (bus.awvalid && bus.awready) begin
      chk("awaddr", bus.awaddr, cfg_base + m_ptr);
      chk("awsize", bus.awsize, 3'd6);
      chk("awid", bus.awid, 16'h0);
      len = int'(bus.awlen) + 1;
      aw_len_q.push_back(len);
      aw_bcnt.push_back(nb);
      last_len = len - 1;
      naws++;
      nxt = m_ptr + 64'(len) * 64'd64;
      if (nxt % 64'h1000 != 0) nxt = nxt + (64'h1000 - nxt % 64'h1000);
      m_ptr = (nxt >= cfg_size) ? 64'd0 : nxt;
    end
    if (bus.wvalid && bus.wready) begin
      nw++;
      chk("w_has_aw", (aw_len_q.size() > 0) ? 1 : 0, 1);
      chk("w_has_data", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) chk("wdata", bus.wdata, sb.pop_front());
      chk("wstrb", bus.wstrb, {64{1'b1}});
      m_cnt--;
      if (aw_len_q.size() > 0) begin
        chk("wlast", bus.wlast, (cur_beat == aw_len_q[0] - 1) ? 1 : 0);
        cur_beat++;
        if (cur_beat == aw_len_q[0]) begin
          pend_b.push_back(64'(aw_len_q[0]) * 64'd64);
          void'(aw_len_q.pop_front());
          cur_beat = 0;
        end
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      sb.push_back(bus.in_data);
      m_cnt++;
      to_send--;
      next_data = rand_word();
    end
    if (bus.bvalid) begin
      chk("bready", bus.bready, 1);
      m_done = m_done + pend_b.pop_front();
      nb++;
      b_budget--;
    end
  endtask

  task automatic feed_all(input int max_cyc);
    bit ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (to_send == 0) begin ok = 1; break; end
      step();
    end
    chk("all_beats_accepted", ok, 1);
  endtask

  task automatic run_until_idle(input int max_cyc);
    int stable = 0;
    bit ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (idle === 1'b1 && to_send == 0 && pend_b.size() == 0) stable++;
      else stable = 0;
      if (stable >= 3) begin ok = 1; break; end
    end
    chk("reached_idle", ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rows[0] = '{64,  1'b0, 64'h4000, 1, 63, 64'h1000, 64'h1000};
    rows[1] = '{5,   1'b1, 64'h4000, 1, 4,  64'h1000, 64'h140};
    rows[2] = '{256, 1'b0, 64'h2000, 4, 63, 64'h0,    64'h4000};
    rows[3] = '{100, 1'b1, 64'h4000, 2, 35, 64'h2000, 64'h1900};
    rows[4] = '{0,   1'b1, 64'h4000, 0, -1, 64'h0,    64'h0};
    rows[5] = '{128, 1'b0, 64'h1000, 2, 63, 64'h0,    64'h2000};
    rows[6] = '{3,   1'b1, 64'h1000, 1, 2,  64'h0,    64'hC0};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    next_data = rand_word();

    // Reset state and in_ready release timing
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_wlast", bus.wlast, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_bytes_done", bytes_done, 0);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
    rstn = 1'b1;
    #1 chk("in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1 chk("in_ready_after_edge", bus.in_ready, 1);

    // Table-driven burst scenarios
    for (int r = 0; r < 7; r++) begin
      do_reset();
      cfg_size = rows[r].size;
      cfg_en   = 1'b1;
      to_send  = rows[r].beats;
      feed_all(2000);
      if (rows[r].fl) begin flush_req = 1; step(); flush_req = 0; end
      run_until_idle(3000);
      chk($sformatf("row%0d_aws", r), naws, rows[r].exp_aws);
      chk($sformatf("row%0d_last_len", r), last_len, rows[r].exp_last);
      chk($sformatf("row%0d_wbeats", r), nw, rows[r].beats);
      chk($sformatf("row%0d_wr_ptr", r), wr_ptr, rows[r].exp_ptr);
      chk($sformatf("row%0d_bytes_done", r), bytes_done, rows[r].exp_done);
      chk($sformatf("row%0d_idle", r), idle, 1);
    end

    // Outstanding limit: no B responses, only 8 AWs until one B arrives
    do_reset();
    cfg_size = 64'h10000; cfg_en = 1'b1; b_budget = 0; to_send = 1024;
    repeat (1500) step();
    chk("outst_aws_held", naws, 8);
    chk("outst_no_b", nb, 0);
    b_budget = 1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin step(); if (naws >= 9) begin ok = 1; break; end end
    chk("outst_ninth_aw", ok, 1);
    chk("outst_ninth_after_b", (aw_bcnt.size() > 8) ? aw_bcnt[8] : -1, 1);
    b_budget = 1 << 30;
    run_until_idle(6000);
    chk("outst_total_aws", naws, 16);
    chk("outst_bytes_done", bytes_done, 64'h10000);
    chk("outst_wr_ptr", wr_ptr, 64'h0);

    // Error response on the second burst is sticky and still counted
    do_reset();
    cfg_size = 64'h4000; cfg_en = 1'b1; err_idx = 1; to_send = 192;
    run_until_idle(2000);
    chk("err_set", err, 1);
    chk("err_bytes_done", bytes_done, 64'h3000);
    err_idx = -1; to_send = 64;
    run_until_idle(1000);
    chk("err_sticky", err, 1);
    chk("err_bytes_done2", bytes_done, 64'h4000);
    do_reset();
    chk("err_cleared_by_reset", err, 0);

    // cfg_en drop mid-burst: current burst completes, no new one starts
    do_reset();
    cfg_size = 64'h4000; cfg_en = 1'b1; to_send = 128;
    ok = 0;
    for (int i = 0; i < 300; i++) begin step(); if (naws >= 1) begin ok = 1; break; end end
    chk("en_first_aw", ok, 1);
    cfg_en = 1'b0;
    repeat (300) step();
    chk("en_aws_stopped", naws, 1);
    chk("en_burst_completed", nw, 64);
    chk("en_not_idle", idle, 0);
    cfg_en = 1'b1;
    run_until_idle(1000);
    chk("en_resume_aws", naws, 2);
    chk("en_bytes_done", bytes_done, 64'h2000);

    // Reset in the middle of a W burst abandons it at once
    do_reset();
    cfg_size = 64'h4000; cfg_en = 1'b1; to_send = 64;
    ok = 0;
    for (int i = 0; i < 400; i++) begin step(); if (nw >= 10) begin ok = 1; break; end end
    chk("mid_reached_data", ok, 1);
    rstn = 1'b0;
    #1;
    chk("mid_wvalid", bus.wvalid, 0);
    chk("mid_awvalid", bus.awvalid, 0);
    chk("mid_in_ready", bus.in_ready, 0);
    chk("mid_wr_ptr", wr_ptr, 0);
    chk("mid_idle", idle, 1);

    // Random handshakes: fill FIFO to full with bursts disabled, then drain
    do_reset();
    cfg_size = 64'h3000; cfg_en = 1'b0; rnd = 1; to_send = 640;
    repeat (700) step();
    chk("rnd_fifo_full", m_cnt, 128);
    cfg_en = 1'b1;
    run_until_idle(20000);
    rnd = 0;
    chk("rnd_aws", naws, 10);
    chk("rnd_bytes_done", bytes_done, 64'hA000);
    chk("rnd_model_done", bytes_done, m_done);
    chk("rnd_wr_ptr", wr_ptr, 64'h1000);
    chk("rnd_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
